// File: rtl/input_event_scheduler.sv
// rtl/input_event_scheduler.sv - button press scheduler: pending register, lowest-index arbiter, FWFT command FIFO
//
// Ports:
//   clk              in   sole clock, rising edge
//   reset            in   asynchronous active-low reset
//   btn_pulse[11:0]  in   one-cycle press pulses, bit i = button i
//   enable           in   1 = accept new presses
//   flush            in   synchronous clear of pending presses and FIFO
//   cmd_valid        out  FIFO head holds a command
//   cmd_code[3:0]    out  button index at FIFO head, 0 when empty
//   cmd_ready        in   consumer accepts head
//   block_controller out  registered back-pressure to the debouncers
//   fifo_level       out  FIFO occupancy 0..DEPTH
//   drop_count[7:0]  out  saturating count of dropped presses (EVT_DROP_COUNT_EN only)
//
// Optional feature macro: EVT_DROP_COUNT_EN
module input_event_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              btn_pulse,
    input  logic                     enable,
    input  logic                     flush,
    output logic                     cmd_valid,
    output logic [3:0]               cmd_code,
    input  logic                     cmd_ready,
    output logic                     block_controller,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef EVT_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] NEAR_FULL = LW'(DEPTH - 1);

    logic [11:0]   pending_q, pending_d;
    logic [11:0]   grant;
    logic [11:0]   accepted;
    logic [3:0]    grant_idx;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          block_q, block_d;
    logic          push, pop, push_ok;

    always_comb begin
        pop      = (level_q != '0) && cmd_ready;
        // A full FIFO can still take a push when the head leaves in the same cycle.
        push_ok  = (level_q != DEPTH_L) || pop;
        accepted = btn_pulse & {12{enable}};

        // Descending scan so the lowest set index is the last one written.
        grant_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx = 4'(i);
            end
        end
        push  = push_ok && (pending_q != '0);
        grant = push ? (12'b1 << grant_idx) : 12'b0;

        // A fresh pulse on the granted bit re-arms it; on any other pending bit it merges away.
        pending_d = (pending_q & ~grant) | accepted;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = grant_idx;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (flush) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end

        block_d = (level_d >= NEAR_FULL) || !enable;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            block_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            block_q   <= block_d;
        end
    end

    // Storage needs no reset: an entry is only visible once level covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd_valid        = (level_q != '0);
    assign cmd_code         = cmd_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign block_controller = block_q;
    assign fifo_level       = level_q;

`ifdef EVT_DROP_COUNT_EN
    logic [7:0]  drop_q, drop_d;
    logic [11:0] drop_bits;
    logic [3:0]  drop_n;
    logic [8:0]  drop_sum;

    always_comb begin
        // Presses that land on a bit still waiting (and not leaving this cycle) are lost.
        drop_bits = accepted & pending_q & ~grant;
        drop_n    = 4'd0;
        for (int i = 0; i < 12; i++) begin
            drop_n = drop_n + {3'b0, drop_bits[i]};
        end
        drop_sum = {1'b0, drop_q} + {5'b0, drop_n};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (flush) begin
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_input_event_scheduler.sv
// tb/tb_input_event_scheduler.sv - directed scoreboard bench for input_event_scheduler
module tb_input_event_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] btn_pulse;
    logic        enable;
    logic        flush;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic        cmd_ready;
    logic        block_controller;
    logic [2:0]  fifo_level;
`ifdef EVT_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    input_event_scheduler #(.DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_pulse        (btn_pulse),
        .enable           (enable),
        .flush            (flush),
        .cmd_valid        (cmd_valid),
        .cmd_code         (cmd_code),
        .cmd_ready        (cmd_ready),
        .block_controller (block_controller),
        .fifo_level       (fifo_level)
`ifdef EVT_DROP_COUNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare any handshake about to happen against the scoreboard, then advance one clock.
    task automatic cycle();
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", {28'd0, cmd_code}, 32'd99);
            end else begin
                chk("scoreboard_code", {28'd0, cmd_code}, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b0;
        btn_pulse = '0;
        enable    = 1'b0;
        flush     = 1'b0;
        cmd_ready = 1'b0;
        #1;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_block", block_controller, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        enable    = 1'b1;
        cmd_ready = 1'b1;
        cycle();
        chk("idle_block", block_controller, 0);
        chk("idle_valid", cmd_valid, 0);

        // Single pulse: valid two edges later for exactly one cycle.
        btn_pulse = 12'h020;
        exp_q.push_back(5);
        cycle();
        btn_pulse = '0;
        chk("lat_n1_valid", cmd_valid, 0);
        cycle();
        chk("lat_n2_valid", cmd_valid, 1);
        chk("lat_n2_code", cmd_code, 5);
        cycle();
        chk("lat_n3_valid", cmd_valid, 0);
        chk("lat_n3_level", fifo_level, 0);

        // Three presses in one cycle come out lowest index first.
        btn_pulse = 12'h811;
        exp_q.push_back(0);
        exp_q.push_back(4);
        exp_q.push_back(11);
        cycle();
        btn_pulse = '0;
        cycle();
        chk("multi_code0", cmd_code, 0);
        cycle();
        chk("multi_code1", cmd_code, 4);
        cycle();
        chk("multi_code2", cmd_code, 11);
        cycle();
        chk("multi_end_valid", cmd_valid, 0);

        // Fill with consumer stalled; back-pressure from level 3.
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_pulse = 12'(1 << i);
            exp_q.push_back(i);
            cycle();
            chk("fill_level", fifo_level, (i > 4) ? 4 : i);
            chk("fill_block", block_controller, (i >= 3) ? 1 : 0);
        end
        btn_pulse = '0;
        cycle();
        chk("full_level", fifo_level, 4);
        chk("full_code_stable", cmd_code, 0);
        cycle();
        chk("full_code_stable2", cmd_code, 0);
        cmd_ready = 1'b1;
        drain(30);
        chk("fill_drained_valid", cmd_valid, 0);
        chk("fill_drained_level", fifo_level, 0);

        // enable low: no new presses accepted, queued ones still drain.
        cmd_ready = 1'b0;
        btn_pulse = 12'h002;
        exp_q.push_back(1);
        cycle();
        btn_pulse = 12'h004;
        exp_q.push_back(2);
        cycle();
        btn_pulse = '0;
        cycle();
        chk("en_queued_level", fifo_level, 2);
        enable    = 1'b0;
        btn_pulse = 12'h008;
        cmd_ready = 1'b1;
        cycle();
        chk("en_block", block_controller, 1);
        cycle();
        cycle();
        btn_pulse = '0;
        repeat (4) cycle();
        chk("en_sb_empty", exp_q.size(), 0);
        chk("en_no_cmd", cmd_valid, 0);
        chk("en_block_hold", block_controller, 1);
        enable = 1'b1;
        cycle();
        chk("en_unblock", block_controller, 0);

        // Full FIFO with bit 2 waiting: further bit-2 presses drop; flush clears everything.
        cmd_ready = 1'b0;
        btn_pulse = 12'h001; exp_q.push_back(0); cycle();
        btn_pulse = 12'h002; exp_q.push_back(1); cycle();
        btn_pulse = 12'h008; exp_q.push_back(3); cycle();
        btn_pulse = 12'h020; exp_q.push_back(5); cycle();
        btn_pulse = 12'h004; cycle();
        btn_pulse = '0;
        cycle();
        cycle();
        chk("fl_full_level", fifo_level, 4);
        chk("fl_full_code", cmd_code, 0);
        btn_pulse = 12'h004; cycle();
        btn_pulse = 12'h004; cycle();
        btn_pulse = '0;
        cycle();
`ifdef EVT_DROP_COUNT_EN
        chk("drop_count_2", drop_count, 2);
`endif
        flush     = 1'b1;
        btn_pulse = 12'h080;
        cycle();
        flush     = 1'b0;
        btn_pulse = '0;
        exp_q.delete();
        chk("fl_valid", cmd_valid, 0);
        chk("fl_level", fifo_level, 0);
        chk("fl_code", cmd_code, 0);
        chk("fl_block", block_controller, 0);
`ifdef EVT_DROP_COUNT_EN
        chk("drop_count_flush", drop_count, 0);
`endif
        cmd_ready = 1'b1;
        repeat (4) cycle();
        chk("fl_no_stale", cmd_valid, 0);

        // Reset mid-drain discards everything immediately.
        cmd_ready = 1'b0;
        btn_pulse = 12'h040; exp_q.push_back(6); cycle();
        btn_pulse = 12'h080; exp_q.push_back(7); cycle();
        btn_pulse = 12'h100; exp_q.push_back(8); cycle();
        btn_pulse = '0;
        cycle();
        chk("rm_level3", fifo_level, 3);
        cmd_ready = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("rm_valid", cmd_valid, 0);
        chk("rm_level", fifo_level, 0);
        chk("rm_code", cmd_code, 0);
        chk("rm_block", block_controller, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) cycle();
        chk("rm_after_valid", cmd_valid, 0);
        chk("rm_after_level", fifo_level, 0);
        btn_pulse = 12'h200;
        exp_q.push_back(9);
        cycle();
        btn_pulse = '0;
        drain(8);
        chk("final_valid", cmd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_event_scheduler.md
INPUT_EVENT_SCHEDULER -- requirements
Module: input_event_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btn_pulse  input  12  one-cycle press pulses from the debounced controller; bit i = button i.
REQ-005 enable  input  1  1 = accept new presses; 0 = ignore btn_pulse.
REQ-006 flush  input  1  synchronous clear of pending presses and FIFO.
REQ-007 cmd_valid  output  1  FIFO head holds a command.
REQ-008 cmd_code  output  4  button index 0..11 at FIFO head; 0 when cmd_valid=0.
REQ-009 cmd_ready  input  1  consumer accepts head when high with cmd_valid.
REQ-010 block_controller  output  1  registered back-pressure to the debouncers.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy 0..DEPTH.

Function
REQ-012 Pending register (12 bits) SHALL capture presses: pending_next = (pending & ~grant) | (btn_pulse & {12{enable}}).
REQ-013 Arbiter SHALL grant at most one pending bit per cycle, lowest index first, only when a push is allowed (REQ-016).
REQ-014 A new pulse on the bit granted in the same cycle SHALL leave that bit pending.
REQ-015 A pulse on a bit already pending and not granted that cycle SHALL be dropped.
REQ-016 Push allowed when fifo_level < DEPTH, or fifo_level = DEPTH with a pop in the same cycle.
REQ-017 Granted index SHALL be written to FIFO tail; FIFO is first-word-fall-through, in-order.
REQ-018 Pop SHALL occur when cmd_valid && cmd_ready; cmd_valid = (fifo_level != 0).
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-020 Latency: single pulse at cycle N with pending and FIFO empty -> cmd_valid=1 with its code at cycle N+2.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH.
REQ-022 flush=1 SHALL clear pending, pointers and level at next edge; overrides push, pop and new pulses that cycle.
REQ-023 block_controller SHALL be registered, 1 when next fifo_level >= DEPTH-1 or enable=0, else 0.
REQ-024 enable=0 SHALL not clear pending or FIFO; queued commands continue to drain.
REQ-025 cmd_code and cmd_valid SHALL be stable while cmd_valid=1 and cmd_ready=0.

Reset
REQ-026 reset low SHALL asynchronously clear pending, pointers, fifo_level, block_controller (0), cmd_valid (0), cmd_code (0).
REQ-027 Reset asserted mid-operation SHALL discard all queued and pending presses; no command appears until a new pulse after reset release.
REQ-028 Reset deassertion is assumed synchronized externally; first active edge behaves as idle.

Configuration
REQ-029 Macro EVT_DROP_COUNT_EN defined: output drop_count (8 bits) counts presses dropped per REQ-015 plus presses granted-blocked never applies; saturates at 255; cleared by reset and flush.
REQ-030 Multiple drops in one cycle SHALL add their count (saturating) when EVT_DROP_COUNT_EN defined.
REQ-031 EVT_DROP_COUNT_EN undefined: drop_count port and counter logic absent; all other behaviour identical.

Verification
REQ-032 Pulse bit 5 at cycle 10, cmd_ready=1 -> cmd_valid=1, cmd_code=5 at cycle 12 only; level returns 0 at 13.
REQ-033 btn_pulse=12'h811 in one cycle, cmd_ready=1 -> codes 0, 4, 11 on consecutive cycles.
REQ-034 DEPTH=4, cmd_ready=0, pulses on bits 0..5 one per cycle -> level 4, block_controller=1 once level reaches 3, codes 4,5 stay pending; raising cmd_ready yields 0,1,2,3,4,5.
REQ-035 With EVT_DROP_COUNT_EN, FIFO full, bit 2 pending, pulse bit 2 twice -> drop_count=2; flush -> drop_count=0, cmd_valid=0 next cycle.
REQ-036 Three commands queued, reset low for one cycle mid-drain -> cmd_valid=0 immediately, fifo_level=0, no stale codes after release.
REQ-037 enable=0 with pulses on bit 3 -> no command, block_controller=1; queued commands still drain.
